// File: rtl/router_pkt_check.sv
// router_pkt_check
//   Packet datapath checker for a simple byte router. Forwards the header,
//   payload and parity bytes to the FIFO, buffers one byte while the FIFO is
//   full, accumulates a running XOR parity or modulo-2^DW sum, counts payload
//   bytes, and after the parity byte compares the result against the received
//   parity and the header length field.
//
// Ports
//   clk, resetn                : clock, async active-low reset
//   pkt_valid, data_in         : incoming byte stream (pkt_valid=0 -> parity byte)
//   fifo_full                  : FIFO cannot accept a byte this cycle
//   detect_add                 : start of packet, header on data_in
//   lfd_state/ld_state/laf_state/full_state : router FSM state flags
//   rst_int_reg                : clears low_pkt_valid
//   dout, dout_valid           : byte to FIFO and its write strobe
//   parity_done, low_pkt_valid : packet end status
//   err, err_code[1:0]         : sticky result, bit0 parity, bit1 length
//   pay_cnt                    : payload bytes counted, saturating
module router_pkt_check #(
    parameter int DW       = 8,
    parameter int PAR_MODE = 0
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          pkt_valid,
    input  logic [DW-1:0] data_in,
    input  logic          fifo_full,
    input  logic          detect_add,
    input  logic          ld_state,
    input  logic          lfd_state,
    input  logic          laf_state,
    input  logic          full_state,
    input  logic          rst_int_reg,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          parity_done,
    output logic          low_pkt_valid,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [DW-3:0] pay_cnt
);

    localparam logic [DW-3:0] CNT_ONE = 1;
    localparam logic [DW-3:0] CNT_MAX = '1;

    logic [DW-1:0] hdr_q, hdr_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          hold_valid_q, hold_valid_d;
    logic          hold_is_par_q, hold_is_par_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] par_q, par_d;
    logic          check_done_q, check_done_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          dout_valid_q, dout_valid_d;
    logic          parity_done_q, parity_done_d;
    logic          low_pkt_valid_q, low_pkt_valid_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [DW-3:0] pay_cnt_q, pay_cnt_d;

    function automatic logic [DW-1:0] absorb(input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (PAR_MODE == 1) return a + b;
        else               return a ^ b;
    endfunction

    function automatic logic [DW-3:0] cnt_inc(input logic [DW-3:0] c);
        return (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    always_comb begin
        hdr_d           = hdr_q;
        hold_d          = hold_q;
        hold_valid_d    = hold_valid_q;
        hold_is_par_d   = hold_is_par_q;
        acc_d           = acc_q;
        par_d           = par_q;
        check_done_d    = check_done_q;
        dout_d          = dout_q;
        dout_valid_d    = 1'b0;
        parity_done_d   = parity_done_q;
        low_pkt_valid_d = low_pkt_valid_q;
        err_d           = err_q;
        err_code_d      = err_code_q;
        pay_cnt_d       = pay_cnt_q;

        if (detect_add) begin
            // New packet: nothing else acts this cycle.
            if (pkt_valid) hdr_d = data_in;
            acc_d         = '0;
            pay_cnt_d     = '0;
            parity_done_d = 1'b0;
            err_d         = 1'b0;
            err_code_d    = '0;
            check_done_d  = 1'b0;
            hold_valid_d  = 1'b0;
        end else begin
            // FIFO write mux; every byte written is absorbed except parity
            // bytes and ld bytes blocked by full_state.
            if (lfd_state) begin
                dout_d       = hdr_q;
                dout_valid_d = 1'b1;
                acc_d        = absorb(acc_q, hdr_q);
            end else if (ld_state && !fifo_full) begin
                dout_d       = data_in;
                dout_valid_d = 1'b1;
                if (pkt_valid && !full_state) begin
                    acc_d     = absorb(acc_q, data_in);
                    pay_cnt_d = cnt_inc(pay_cnt_q);
                end
            end else if (laf_state && hold_valid_q) begin
                dout_d       = hold_q;
                dout_valid_d = 1'b1;
                hold_valid_d = 1'b0;
                if (!hold_is_par_q) begin
                    acc_d     = absorb(acc_q, hold_q);
                    pay_cnt_d = cnt_inc(pay_cnt_q);
                end
            end

            // FIFO full: park the byte until the laf drain.
            if (ld_state && fifo_full) begin
                hold_d        = data_in;
                hold_valid_d  = 1'b1;
                hold_is_par_d = !pkt_valid;
            end

            if (ld_state && !pkt_valid) begin
                par_d           = data_in;
                low_pkt_valid_d = 1'b1;
            end
            if (rst_int_reg) low_pkt_valid_d = 1'b0;

            // Second term covers a parity byte that was parked in the hold
            // register and only reaches the FIFO during laf.
            if ((ld_state && !fifo_full && !pkt_valid) ||
                (laf_state && low_pkt_valid_q && !parity_done_q))
                parity_done_d = 1'b1;

            // One-shot check, one cycle after parity_done rises, so the
            // accumulator and parity register are both settled.
            if (parity_done_q && !check_done_q) begin
                err_code_d[0] = (acc_q != par_q);
                err_code_d[1] = (pay_cnt_q != hdr_q[DW-1:2]);
                err_d         = |err_code_d;
                check_done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hdr_q           <= '0;
            hold_q          <= '0;
            hold_valid_q    <= 1'b0;
            hold_is_par_q   <= 1'b0;
            acc_q           <= '0;
            par_q           <= '0;
            check_done_q    <= 1'b0;
            dout_q          <= '0;
            dout_valid_q    <= 1'b0;
            parity_done_q   <= 1'b0;
            low_pkt_valid_q <= 1'b0;
            err_q           <= 1'b0;
            err_code_q      <= '0;
            pay_cnt_q       <= '0;
        end else begin
            hdr_q           <= hdr_d;
            hold_q          <= hold_d;
            hold_valid_q    <= hold_valid_d;
            hold_is_par_q   <= hold_is_par_d;
            acc_q           <= acc_d;
            par_q           <= par_d;
            check_done_q    <= check_done_d;
            dout_q          <= dout_d;
            dout_valid_q    <= dout_valid_d;
            parity_done_q   <= parity_done_d;
            low_pkt_valid_q <= low_pkt_valid_d;
            err_q           <= err_d;
            err_code_q      <= err_code_d;
            pay_cnt_q       <= pay_cnt_d;
        end
    end

    assign dout          = dout_q;
    assign dout_valid    = dout_valid_q;
    assign parity_done   = parity_done_q;
    assign low_pkt_valid = low_pkt_valid_q;
    assign err           = err_q;
    assign err_code      = err_code_q;
    assign pay_cnt       = pay_cnt_q;

endmodule

// File: tb/tb_router_pkt_check.sv
// Bench for router_pkt_check: one XOR-parity and one sum-checksum instance
// share all inputs; a router FSM sequence is emulated and outputs are
// compared against a packet-level reference model.
module tb_router_pkt_check;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic resetn, pkt_valid, fifo_full, detect_add, ld_state, lfd_state;
    logic laf_state, full_state, rst_int_reg;
    logic [7:0] data_in;

    logic [7:0] dout_x, dout_s;
    logic       dv_x, dv_s, pd_x, pd_s, lpv_x, lpv_s, err_x, err_s;
    logic [1:0] ec_x, ec_s;
    logic [5:0] cnt_x, cnt_s;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    router_pkt_check #(.DW(DW), .PAR_MODE(0)) u_xor (
        .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .detect_add(detect_add), .ld_state(ld_state),
        .lfd_state(lfd_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .dout(dout_x), .dout_valid(dv_x),
        .parity_done(pd_x), .low_pkt_valid(lpv_x), .err(err_x),
        .err_code(ec_x), .pay_cnt(cnt_x)
    );

    router_pkt_check #(.DW(DW), .PAR_MODE(1)) u_sum (
        .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .detect_add(detect_add), .ld_state(ld_state),
        .lfd_state(lfd_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .dout(dout_s), .dout_valid(dv_s),
        .parity_done(pd_s), .low_pkt_valid(lpv_s), .err(err_s),
        .err_code(ec_s), .pay_cnt(cnt_s)
    );

    // Observation captured once per clock, #1 after the rising edge.
    logic [7:0] got_x[$], got_s[$];
    int         pd_state;
    logic [1:0] ecx_pd, ecs_pd, ecx_nx, ecs_nx;

    task automatic tick();
        @(posedge clk); #1;
        if (dv_x) got_x.push_back(dout_x);
        if (dv_s) got_s.push_back(dout_s);
        if (pd_state == 1) begin
            ecx_nx = ec_x; ecs_nx = ec_s; pd_state = 2;
        end
        if (pd_state == 0 && pd_x) begin
            ecx_pd = ec_x; ecs_pd = ec_s; pd_state = 1;
        end
    endtask

    // Reference model: fold header and every absorbed payload byte.
    function automatic logic [7:0] m_acc(input bit sum, input logic [7:0] h,
                                         input logic [7:0] pl[$], input bit sk[$]);
        logic [7:0] a;
        a = h;
        foreach (pl[i]) if (!sk[i]) a = sum ? 8'(a + pl[i]) : (a ^ pl[i]);
        return a;
    endfunction

    function automatic int m_cnt(input logic [7:0] pl[$], input bit sk[$]);
        int n;
        n = 0;
        foreach (pl[i]) if (!sk[i]) n++;
        return (n > 63) ? 63 : n;
    endfunction

    task automatic idle_inputs();
        pkt_valid = 0; fifo_full = 0; detect_add = 0; ld_state = 0; lfd_state = 0;
        laf_state = 0; full_state = 0; rst_int_reg = 0; data_in = 0;
    endtask

    // Drive one packet as the router FSM would: decode, lfd, ld per byte,
    // with an laf drain after any byte presented while the FIFO is full.
    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] pl[$],
                            input logic [7:0] par, input bit st[$], input bit fs[$]);
        got_x.delete(); got_s.delete(); pd_state = 0;
        detect_add = 1; pkt_valid = 1; data_in = hdr; tick();
        detect_add = 0; lfd_state = 1;
        data_in = (pl.size() > 0) ? pl[0] : par; tick();
        lfd_state = 0;
        for (int i = 0; i <= pl.size(); i++) begin
            ld_state   = 1;
            pkt_valid  = (i != pl.size());
            data_in    = (i == pl.size()) ? par : pl[i];
            fifo_full  = st[i];
            full_state = fs[i];
            tick();
            full_state = 0;
            if (st[i]) begin
                ld_state = 0; fifo_full = 0; laf_state = 1;
                data_in = 8'($urandom); tick();
                laf_state = 0;
            end
        end
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1;
        #3 resetn = 0;
        #1;
        vectors++;
        if ({dout_x, dv_x, pd_x, lpv_x, err_x, ec_x, cnt_x} !== 20'h0 ||
            {dout_s, dv_s, pd_s, lpv_s, err_s, ec_s, cnt_s} !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_async: x=%h s=%h expected 0",
                     {dout_x, dv_x, pd_x, lpv_x, err_x, ec_x, cnt_x},
                     {dout_s, dv_s, pd_s, lpv_s, err_s, ec_s, cnt_s});
        end
        @(negedge clk); @(negedge clk);
        resetn = 1;
    endtask

    task automatic test_packets();
        logic [7:0] hdr, par;
        logic [7:0] pl[$], exp[$];
        bit st[$], fs[$], sk[$];
        logic [1:0] cx, cs, mx, ms;
        int ccnt, mc;
        for (int c = 0; c < 9; c++) begin
            pl.delete(); st.delete(); fs.delete();
            hdr = 8'h0D; par = 8'h0D;
            pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
            cx = 2'b00; cs = 2'b01; ccnt = 3;
            case (c)
                1: begin par = 8'h0E; cx = 2'b01; cs = 2'b01; end
                2: begin hdr = 8'h11; par = 8'h11; cx = 2'b10; cs = 2'b11; end
                3: begin par = 8'h73; cx = 2'b01; cs = 2'b00; end
                6: begin cx = 2'b11; cs = 2'b11; ccnt = 2; end
                7: begin
                    hdr = 8'hFF; par = 8'hFF; pl.delete();
                    for (int i = 0; i < 70; i++) pl.push_back(8'h01);
                    cx = 2'b00; cs = 2'b01; ccnt = 63;
                end
                8: begin hdr = 8'h00; par = 8'h00; pl.delete(); cx = 2'b00; cs = 2'b00; ccnt = 0; end
                default: ;
            endcase
            for (int i = 0; i <= pl.size(); i++) begin st.push_back(0); fs.push_back(0); end
            if (c == 4) st[1] = 1;   // FIFO full while 0x22 presented
            if (c == 5) st[3] = 1;   // FIFO full on the parity byte
            if (c == 6) fs[0] = 1;   // full_state blocks absorbing 0x11
            sk.delete();
            foreach (pl[i]) sk.push_back(fs[i] && !st[i]);
            mc = m_cnt(pl, sk);
            mx = {mc != int'(hdr[7:2]), m_acc(0, hdr, pl, sk) != par};
            ms = {mc != int'(hdr[7:2]), m_acc(1, hdr, pl, sk) != par};
            exp.delete(); exp.push_back(hdr);
            foreach (pl[i]) exp.push_back(pl[i]);
            exp.push_back(par);

            send_pkt(hdr, pl, par, st, fs);

            vectors++;
            if (got_x.size() != exp.size() || got_s.size() != exp.size()) begin
                miscompares++;
                $display("FAIL pkt%0d stream_len: got %0d/%0d expected %0d", c, got_x.size(), got_s.size(), exp.size());
            end else begin
                foreach (exp[i]) begin
                    vectors++;
                    if (got_x[i] !== exp[i] || got_s[i] !== exp[i]) begin
                        miscompares++;
                        $display("FAIL pkt%0d dout[%0d]: got %h/%h expected %h", c, i, got_x[i], got_s[i], exp[i]);
                    end
                end
            end
            vectors++;
            if (cnt_x !== 6'(ccnt) || cnt_s !== 6'(ccnt) || mc != ccnt) begin
                miscompares++;
                $display("FAIL pkt%0d pay_cnt: got %0d/%0d expected %0d (model %0d)", c, cnt_x, cnt_s, ccnt, mc);
            end
            vectors++;
            if (ec_x !== cx || err_x !== (|cx) || mx !== cx) begin
                miscompares++;
                $display("FAIL pkt%0d xor_err: got ec=%b err=%b expected ec=%b (model %b)", c, ec_x, err_x, cx, mx);
            end
            vectors++;
            if (ec_s !== cs || err_s !== (|cs) || ms !== cs) begin
                miscompares++;
                $display("FAIL pkt%0d sum_err: got ec=%b err=%b expected ec=%b (model %b)", c, ec_s, err_s, cs, ms);
            end
            vectors++;
            if (pd_state != 2 || ecx_pd !== 2'b00 || ecs_pd !== 2'b00 || ecx_nx !== cx || ecs_nx !== cs || pd_s !== 1'b1) begin
                miscompares++;
                $display("FAIL pkt%0d check_timing: got pd_state=%0d at_rise=%b/%b next=%b/%b expected 2 00/00 %b/%b",
                         c, pd_state, ecx_pd, ecs_pd, ecx_nx, ecs_nx, cx, cs);
            end
            vectors++;
            if (lpv_x !== 1'b1 || lpv_s !== 1'b1) begin
                miscompares++;
                $display("FAIL pkt%0d low_pkt_valid_set: got %b/%b expected 1", c, lpv_x, lpv_s);
            end
            rst_int_reg = 1; tick(); rst_int_reg = 0;
            vectors++;
            if (lpv_x !== 1'b0 || lpv_s !== 1'b0) begin
                miscompares++;
                $display("FAIL pkt%0d low_pkt_valid_clr: got %b/%b expected 0", c, lpv_x, lpv_s);
            end
        end
    endtask

    // With no data state active, random inputs must not disturb anything.
    task automatic test_idle();
        logic [7:0] pl[$];
        bit st[$], fs[$];
        pl = {8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 4; i++) begin st.push_back(0); fs.push_back(0); end
        send_pkt(8'h0D, pl, 8'h0D, st, fs);
        rst_int_reg = 1; tick(); rst_int_reg = 0;
        for (int k = 0; k < 6; k++) begin
            data_in = 8'($urandom); pkt_valid = 1'($urandom);
            fifo_full = 1'($urandom); full_state = 1'($urandom);
            tick();
            vectors++;
            if ({dv_x, dout_x, cnt_x, ec_x, err_x, pd_x, lpv_x} !== {1'b0, 8'h0D, 6'd3, 2'b00, 1'b0, 1'b1, 1'b0} ||
                {dv_s, dout_s, cnt_s, ec_s, err_s, pd_s, lpv_s} !== {1'b0, 8'h0D, 6'd3, 2'b01, 1'b1, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL idle%0d: got x=%h s=%h expected x=%h s=%h", k,
                         {dv_x, dout_x, cnt_x, ec_x, err_x, pd_x, lpv_x},
                         {dv_s, dout_s, cnt_s, ec_s, err_s, pd_s, lpv_s},
                         {1'b0, 8'h0D, 6'd3, 2'b00, 1'b0, 1'b1, 1'b0},
                         {1'b0, 8'h0D, 6'd3, 2'b01, 1'b1, 1'b1, 1'b0});
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        logic [7:0] pl[$];
        bit st[$], fs[$];
        detect_add = 1; pkt_valid = 1; data_in = 8'h0D; tick();
        detect_add = 0; lfd_state = 1; data_in = 8'h11; tick();
        lfd_state = 0; ld_state = 1; data_in = 8'h11; tick();
        vectors++;
        if (dout_x !== 8'h11 || dv_x !== 1'b1 || cnt_x !== 6'd1) begin
            miscompares++;
            $display("FAIL mid_pre_reset: got dout=%h dv=%b cnt=%0d expected 11 1 1", dout_x, dv_x, cnt_x);
        end
        #2 resetn = 0;
        #1;
        vectors++;
        if ({dout_x, dv_x, pd_x, lpv_x, err_x, ec_x, cnt_x} !== 20'h0 ||
            {dout_s, dv_s, pd_s, lpv_s, err_s, ec_s, cnt_s} !== 20'h0) begin
            miscompares++;
            $display("FAIL mid_reset_async: x=%h s=%h expected 0",
                     {dout_x, dv_x, pd_x, lpv_x, err_x, ec_x, cnt_x},
                     {dout_s, dv_s, pd_s, lpv_s, err_s, ec_s, cnt_s});
        end
        idle_inputs();
        resetn = 1;
        pl = {8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 4; i++) begin st.push_back(0); fs.push_back(0); end
        send_pkt(8'h0D, pl, 8'h0D, st, fs);
        vectors++;
        if (err_x !== 1'b0 || ec_x !== 2'b00 || cnt_x !== 6'd3 || got_x.size() != 5) begin
            miscompares++;
            $display("FAIL post_reset_pkt: got err=%b ec=%b cnt=%0d bytes=%0d expected 0 00 3 5",
                     err_x, ec_x, cnt_x, got_x.size());
        end
        rst_int_reg = 1; tick(); rst_int_reg = 0;
    endtask

    task automatic test_random();
        logic [7:0] hdr, par;
        logic [7:0] pl[$];
        bit st[$], fs[$], sk[$];
        logic [1:0] mx, ms;
        int len, mc, bad;
        for (int p = 0; p < 30; p++) begin
            len = $urandom_range(0, 20);
            pl.delete(); st.delete(); fs.delete(); sk.delete();
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
            for (int i = 0; i <= len; i++) begin
                st.push_back($urandom_range(0, 3) == 0);
                fs.push_back((i < len) && ($urandom_range(0, 7) == 0));
            end
            foreach (pl[i]) sk.push_back(fs[i] && !st[i]);
            hdr = {($urandom_range(0, 1) == 0) ? 6'(len) : 6'($urandom), 2'($urandom)};
            case ($urandom_range(0, 3))
                0, 1: par = m_acc(0, hdr, pl, sk);
                2:    par = m_acc(1, hdr, pl, sk);
                default: par = 8'($urandom);
            endcase
            mc = m_cnt(pl, sk);
            mx = {mc != int'(hdr[7:2]), m_acc(0, hdr, pl, sk) != par};
            ms = {mc != int'(hdr[7:2]), m_acc(1, hdr, pl, sk) != par};

            send_pkt(hdr, pl, par, st, fs);

            bad = 0;
            if (got_x.size() != len + 2 || got_s.size() != len + 2) bad = 1;
            else begin
                if (got_x[0] !== hdr || got_s[0] !== hdr) bad = 1;
                foreach (pl[i]) if (got_x[i+1] !== pl[i] || got_s[i+1] !== pl[i]) bad = 1;
                if (got_x[len+1] !== par || got_s[len+1] !== par) bad = 1;
            end
            vectors++;
            if (bad != 0) begin
                miscompares++;
                $display("FAIL rnd%0d stream: got %0d/%0d bytes, hdr=%h expected %0d bytes hdr=%h par=%h",
                         p, got_x.size(), got_s.size(), hdr, len + 2, hdr, par);
            end
            vectors++;
            if (cnt_x !== 6'(mc) || cnt_s !== 6'(mc)) begin
                miscompares++;
                $display("FAIL rnd%0d pay_cnt: got %0d/%0d expected %0d", p, cnt_x, cnt_s, mc);
            end
            vectors++;
            if (ec_x !== mx || err_x !== (|mx) || ec_s !== ms || err_s !== (|ms)) begin
                miscompares++;
                $display("FAIL rnd%0d err: got x=%b/%b s=%b/%b expected x=%b/%b s=%b/%b",
                         p, ec_x, err_x, ec_s, err_s, mx, |mx, ms, |ms);
            end
            vectors++;
            if (pd_state != 2 || ecx_pd !== 2'b00 || ecx_nx !== mx || ecs_nx !== ms) begin
                miscompares++;
                $display("FAIL rnd%0d check_timing: got pd_state=%0d at_rise=%b next=%b/%b expected 2 00 %b/%b",
                         p, pd_state, ecx_pd, ecx_nx, ecs_nx, mx, ms);
            end
            rst_int_reg = 1; tick(); rst_int_reg = 0;
        end
    endtask

    initial begin
        pd_state = 0;
        test_reset();
        test_packets();
        test_idle();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/router_pkt_check.md
ROUTER_PKT_CHECK -- requirements
Module: router_pkt_check

Interface
REQ-001 SHALL have parameter DW, default 8: data byte width, legal range 8..32.
REQ-002 SHALL have parameter PAR_MODE, default 0: 0 = XOR parity, 1 = modulo-2^DW sum checksum.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports pkt_valid (input, 1) and data_in (input, DW): packet byte stream; pkt_valid low marks the parity byte.
REQ-006 SHALL have inputs fifo_full, detect_add, ld_state, lfd_state, laf_state, full_state, rst_int_reg, each 1 bit: FSM and FIFO status.
REQ-007 SHALL have outputs dout (DW), dout_valid (1): byte to FIFO; dout_valid is the write strobe.
REQ-008 SHALL have outputs parity_done, low_pkt_valid, err (1 each) and err_code (2): bit0 = parity mismatch, bit1 = length mismatch.
REQ-009 SHALL have output pay_cnt (DW-2): payload bytes counted in the current packet.

Function
REQ-010 Header layout SHALL be: header[1:0] = address, header[DW-1:2] = payload length L.
REQ-011 detect_add && pkt_valid SHALL latch data_in into the header register.
REQ-012 detect_add SHALL clear the accumulator, pay_cnt, parity_done, err, err_code, check_done and hold_valid; detect_add has priority over all other controls in the same cycle.
REQ-013 dout priority SHALL be lfd_state, then ld_state && !fifo_full, then laf_state && hold_valid; otherwise dout holds its value.
  - lfd_state: dout <= header.
  - ld_state && !fifo_full: dout <= data_in.
  - laf_state && hold_valid: dout <= hold register.
REQ-014 dout_valid SHALL be 1 exactly in the cycle after each dout load in REQ-013, else 0.
REQ-015 ld_state && fifo_full SHALL latch data_in into the hold register, set hold_valid and latch hold_is_par = !pkt_valid; the laf_state drain clears hold_valid.
REQ-016 The accumulator SHALL absorb each byte in the same cycle it is loaded to dout: the header (lfd), each payload byte, and each held payload byte (laf with !hold_is_par).
  - Parity bytes are never absorbed.
  - Absorb operator: acc ^ b (PAR_MODE=0) or (acc + b) mod 2^DW (PAR_MODE=1).
REQ-017 pay_cnt SHALL increment on each absorbed payload byte and saturate at 2^(DW-2)-1.
REQ-018 ld_state && !pkt_valid SHALL latch data_in into the packet-parity register, whether or not fifo_full is asserted.
REQ-019 low_pkt_valid SHALL set on ld_state && !pkt_valid and clear on rst_int_reg; rst_int_reg wins if both occur in one cycle.
REQ-020 parity_done SHALL set on either of two conditions:
  - ld_state && !fifo_full && !pkt_valid;
  - laf_state && low_pkt_valid && !parity_done.
  It then stays 1 until detect_add or reset.
REQ-021 In the first cycle with parity_done=1 && check_done=0, the block SHALL perform the check:
  - err_code[0] <= (acc != packet parity);
  - err_code[1] <= (pay_cnt != L);
  - err <= |err_code (from the new values);
  - check_done <= 1.
  The result is visible one cycle after parity_done rises and is sticky until detect_add.
REQ-022 full_state SHALL block accumulator updates from ld_state in the same cycle.
REQ-023 When lfd_state, ld_state and laf_state are all 0, no register other than dout_valid (forced to 0) SHALL change.

Reset
REQ-024 resetn low SHALL immediately, without waiting for clk, force every output and every internal register (header, hold, accumulator, parity, check_done) to 0.
REQ-025 A reset asserted mid-packet SHALL discard the packet; the block resumes only on the next detect_add.

Verification
REQ-026 DW=8, PAR_MODE=0: header 0x0D (L=3), payload 11,22,33, parity 0x0D -> dout 0D,11,22,33,0D; pay_cnt=3; err=0, err_code=00 one cycle after parity_done.
REQ-027 Same as REQ-026 but parity 0x0E -> err=1, err_code=01.
REQ-028 Header 0x11 (L=4), payload 11,22,33, parity 0x11 -> err=1, err_code=10.
REQ-029 PAR_MODE=1: header 0x0D, payload 11,22,33, parity 0x73 -> err=0; parity 0x0D -> err_code=01.
REQ-030 fifo_full high while 0x22 is presented in ld_state, then laf_state -> hold register=0x22; dout=0x22 with dout_valid; accumulator result unchanged versus REQ-026.
REQ-031 resetn pulsed low after payload byte 0x11 -> all outputs 0 asynchronously; after reset, a full REQ-026 packet -> err=0.
